step_watchdog: RTL and testbench
================================

# step_watchdog

Parametrised step-activity watchdog for the motion controller top level. Monitors NCHAN step outputs, keeps a per-channel idle counter with a runtime-programmable timeout, raises per-channel alerts, and drives a sticky shutdown request when an armed, masked channel stalls. It replaces the fixed six-channel, fixed-timeout inline watcher; its alert and debug outputs feed the LED-matrix debug bus and `req_shutdown` feeds the command core.

## Interface
- `NCHAN`, 6, number of monitored step channels (1..16)
- `HZ`, 48000000, system clock frequency
- `CNT_BITS`, 32, idle counter and timeout width
- `DEFAULT_TIMEOUT`, HZ*10, per-channel timeout after reset, in cycles; 0 disables the channel
- `CHAN_BITS`, $clog2(NCHAN) (min 1), channel index width
---
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `step`  in  NCHAN  step signals; any level change counts as activity
- `shutdown_mask`  in  NCHAN  channels allowed to trip shutdown
- `arm`  in  1  single-cycle arm request
- `disarm`  in  1  single-cycle disarm request
- `clr`  in  1  clear trip and return to DISARMED
- `cfg_wr`  in  1  timeout write strobe
- `cfg_chan`  in  CHAN_BITS  channel written
- `cfg_timeout`  in  CNT_BITS  new timeout in cycles
- `alert`  out  NCHAN  channel idle count has reached its nonzero timeout
- `armed`  out  1  state is ARMED
- `req_shutdown`  out  1  sticky shutdown request
- `fault_valid`  out  1  `fault_chan` holds the tripping channel
- `fault_chan`  out  CHAN_BITS  lowest-index channel that tripped
- `dbg_idle_msb`  out  8  bits [CNT_BITS-1 -: 8] of channel NCHAN-1's counter

## Operation
- Edge detect per channel: `prev[i]` register; `edge[i] = step[i] != prev[i]`.
- Counter per channel: if edge, it goes to 0. Otherwise it increments while `count != timeout` and saturates at `timeout`. It never wraps.
- `alert[i] = (count[i] == timeout[i]) && (timeout[i] != 0)`. Decoded from registers only, with no combinational path from `step`.
- Edge and saturation in the same cycle: the edge wins, and the counter goes to 0.
- Timeout write: `cfg_wr` with `cfg_chan < NCHAN` loads `timeout[cfg_chan]` and zeroes that counter. A write with `cfg_chan >= NCHAN` is ignored.
- State machine, DISARMED / ARMED / TRIPPED:
  - DISARMED -> ARMED on `arm`.
  - ARMED -> DISARMED on `disarm` or `clr`.
  - ARMED -> TRIPPED when `|(alert & shutdown_mask)` is true: set `req_shutdown`, `fault_valid`, and `fault_chan` = lowest set bit.
  - TRIPPED -> DISARMED only on `clr`. This drops `req_shutdown` and `fault_valid`; `fault_chan` holds its value.
- Priority within a cycle: `clr` > `disarm` > trip > `arm`.
- An `arm` while any masked alert is already set enters ARMED; the trip follows one cycle later.
- In DISARMED, alerts still track activity but never trip.

## Timing
- Reset values:
  - `prev` <= `step` (no spurious edge).
  - Counters 0; timeouts `DEFAULT_TIMEOUT`.
  - State DISARMED.
  - `alert` 0 (unless DEFAULT_TIMEOUT is 0, which keeps it 0 anyway).
  - `armed`, `req_shutdown`, `fault_valid` 0; `fault_chan` 0; `dbg_idle_msb` 0.
- Step change sampled at edge e: counter is 0 after e+1, and `alert` asserts at e+1+T for timeout T. Alert deasserts one cycle after the next step change is sampled.
- Trip latency: `req_shutdown` goes high on the clock edge after the masked `alert` is high (1 cycle).
- `armed` reflects the state register, so it changes 1 cycle after `arm`/`disarm`.
- A `rst` asserted mid-count or while TRIPPED restores all reset values on the next edge.

## Configuration
- `STEP_WATCHDOG_SYNC_EN`:
  - Defined: `step` passes through a 2-flop synchronizer per channel before edge detection. Reset loads the synchronizer with `step`. All step-related latencies grow by 2 cycles. Use this when `step` comes from external pins.
  - Undefined: `step` is used directly (internal, same-clock sources).

## Structure
- Package `step_watchdog_pkg` holds:
  - the state enum (`WD_DISARMED`, `WD_ARMED`, `WD_TRIPPED`);
  - the `DEFAULT_TIMEOUT` helper constant;
  - the priority-encoder function used for `fault_chan`.
- Sub-module `step_wd_chan`, one instance per channel, generate loop. It contains the optional synchronizer, edge detect, counter, timeout register and alert decode.
- The top contains the state machine, fault latch and config decode.

## Test plan
- Timeout ch0 = 100, no steps on ch0 -> `alert[0]` rises exactly 101 cycles after the write and stays high. Toggle `step[0]` -> alert drops 1 cycle after the toggle is sampled.
- ch2 and ch4 timeouts = 50, mask = 6'b010100, arm, both idle -> `req_shutdown` = 1 one cycle after the alerts, `fault_chan` = 2. `clr` -> `req_shutdown` = 0, state DISARMED.
- Timeout = 0 on ch1, idle for 10000 cycles -> `alert[1]` stays 0; no trip while armed.
- Step change in the exact cycle the counter hits 100 -> counter goes to 0, `alert` never asserts.
- `arm` and `disarm` in the same cycle -> `armed` stays 0. Mask alert and `clr` in the same cycle while ARMED -> no trip.
- Write timeout 10 to ch3 when its counter is at 500 -> counter resets to 0, alert after 11 cycles. `cfg_chan` = 7 with NCHAN = 6 -> no change.

Source files
------------

// File: rtl/step_watchdog_pkg.sv
// step_watchdog_pkg: shared types and helpers for the step-activity watchdog.
// Holds the supervisor state encoding, the default-timeout scale constant
// and the lowest-index priority encoder used to report the tripping channel.
package step_watchdog_pkg;

   // Supervisor states.
   typedef enum logic [1:0] {
      WD_DISARMED = 2'd0,
      WD_ARMED    = 2'd1,
      WD_TRIPPED  = 2'd2
   } wd_state_e;

   // Default per-channel timeout is this many seconds of clock cycles.
   localparam int unsigned WD_TIMEOUT_SECONDS = 10;

   // Widest channel vector the priority encoder handles.
   localparam int unsigned WD_MAX_CHAN = 16;

   // Index of the lowest set bit of vec; 0 when vec is all zeros.
   function automatic logic [3:0] wd_lowest_set(input logic [WD_MAX_CHAN-1:0] vec);
      logic [3:0] idx;
      idx = '0;
      for (int i = WD_MAX_CHAN - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/step_wd_chan.sv
// step_wd_chan: one monitored step channel.
// Optional 2-flop input synchronizer (STEP_WATCHDOG_SYNC_EN), level-change
// detector, saturating idle counter, runtime timeout register and a
// registered alert flag. The alert is decoded only from the counter and
// timeout registers, so there is no combinational path from step_in.
module step_wd_chan
   import step_watchdog_pkg::*;
#(
   parameter int unsigned           CNT_BITS        = 32,
   parameter logic [CNT_BITS-1:0]   DEFAULT_TIMEOUT = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                step_in,
   input  logic                cfg_load,
   input  logic [CNT_BITS-1:0] cfg_timeout,
   output logic                alert,
   output logic [7:0]          idle_msb
);

   logic                step_s;
   logic                step_edge;
   logic                prev_q, prev_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic [CNT_BITS-1:0] timeout_q, timeout_d;
   logic                alert_q, alert_d;

`ifdef STEP_WATCHDOG_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   // Synchronizer next-state: shift the raw pin through two flops.
   always_comb begin
      sync1_d = step_in;
      sync2_d = sync1_q;
   end

   // Synchronizer registers; reset preloads the current pin level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= step_in;
         sync2_q <= step_in;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign step_s = sync2_q;
`else
   assign step_s = step_in;
`endif

   // Edge detect, counter, timeout and alert next-state logic.
   always_comb begin
      step_edge = (step_s != prev_q);
      prev_d    = step_s;
      timeout_d = timeout_q;
      count_d   = count_q;
      if (cfg_load) begin
         // A new timeout restarts the idle measurement from zero.
         timeout_d = cfg_timeout;
         count_d   = '0;
      end else if (step_edge) begin
         // Activity beats saturation when both happen in the same cycle.
         count_d = '0;
      end else if (count_q != timeout_q) begin
         count_d = count_q + CNT_BITS'(1);
      end
      alert_d = (count_q == timeout_q) && (timeout_q != '0);
   end

   // Channel state registers; reset takes prev from the live input so
   // that leaving reset never produces a spurious edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q    <= step_in;
         count_q   <= '0;
         timeout_q <= DEFAULT_TIMEOUT;
         alert_q   <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         alert_q   <= alert_d;
      end
   end

   assign alert    = alert_q;
   assign idle_msb = count_q[CNT_BITS-1 -: 8];

endmodule

// File: rtl/step_watchdog.sv
// step_watchdog: NCHAN-channel step-activity watchdog.
// Each channel keeps an idle counter against a programmable timeout and
// raises alert when it saturates. An armed supervisor latches a sticky
// shutdown request, with the lowest tripping channel, when any alert
// selected by shutdown_mask is set. Define STEP_WATCHDOG_SYNC_EN to put a
// 2-flop synchronizer on every step input (external pins).
module step_watchdog
   import step_watchdog_pkg::*;
#(
   parameter int unsigned         NCHAN           = 6,
   parameter int unsigned         HZ              = 48_000_000,
   parameter int unsigned         CNT_BITS        = 32,
   parameter logic [CNT_BITS-1:0] DEFAULT_TIMEOUT = CNT_BITS'(HZ * WD_TIMEOUT_SECONDS),
   parameter int unsigned         CHAN_BITS       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCHAN-1:0]     step,
   input  logic [NCHAN-1:0]     shutdown_mask,
   input  logic                 arm,
   input  logic                 disarm,
   input  logic                 clr,
   input  logic                 cfg_wr,
   input  logic [CHAN_BITS-1:0] cfg_chan,
   input  logic [CNT_BITS-1:0]  cfg_timeout,
   output logic [NCHAN-1:0]     alert,
   output logic                 armed,
   output logic                 req_shutdown,
   output logic                 fault_valid,
   output logic [CHAN_BITS-1:0] fault_chan,
   output logic [7:0]           dbg_idle_msb
);

   wd_state_e            state_q, state_d;
   logic                 req_q, req_d;
   logic                 fvalid_q, fvalid_d;
   logic [CHAN_BITS-1:0] fchan_q, fchan_d;

   logic [NCHAN-1:0]     cfg_load;
   logic [NCHAN-1:0]     trip_vec;
   logic                 trip;

   // Timeout write decode; out-of-range channel numbers select nothing.
   always_comb begin
      cfg_load = '0;
      for (int i = 0; i < int'(NCHAN); i++) begin
         if (cfg_wr && (cfg_chan == CHAN_BITS'(i))) begin
            cfg_load[i] = 1'b1;
         end
      end
   end

   for (genvar i = 0; i < int'(NCHAN); i++) begin : g_chan
      // Only the last channel's counter byte is exported for debug.
      logic [7:0] idle_msb_unused;

      step_wd_chan #(
         .CNT_BITS        (CNT_BITS),
         .DEFAULT_TIMEOUT (DEFAULT_TIMEOUT)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .step_in     (step[i]),
         .cfg_load    (cfg_load[i]),
         .cfg_timeout (cfg_timeout),
         .alert       (alert[i]),
         .idle_msb    (idle_msb_unused)
      );

      if (i == int'(NCHAN) - 1) begin : g_dbg
         assign dbg_idle_msb = idle_msb_unused;
      end
   end

   assign trip_vec = alert & shutdown_mask;
   assign trip     = |trip_vec;

   // Supervisor next-state and fault latch; priority clr > disarm > trip > arm.
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      fvalid_d = fvalid_q;
      fchan_d  = fchan_q;
      case (state_q)
         WD_DISARMED: begin
            if (!clr && !disarm && arm) begin
               state_d = WD_ARMED;
            end
         end
         WD_ARMED: begin
            if (clr || disarm) begin
               state_d = WD_DISARMED;
            end else if (trip) begin
               state_d  = WD_TRIPPED;
               req_d    = 1'b1;
               fvalid_d = 1'b1;
               fchan_d  = CHAN_BITS'(wd_lowest_set(WD_MAX_CHAN'(trip_vec)));
            end
         end
         WD_TRIPPED: begin
            // Only clr leaves TRIPPED; fault_chan keeps the last culprit.
            if (clr) begin
               state_d  = WD_DISARMED;
               req_d    = 1'b0;
               fvalid_d = 1'b0;
            end
         end
         default: begin
            state_d  = WD_DISARMED;
            req_d    = 1'b0;
            fvalid_d = 1'b0;
         end
      endcase
   end

   // Supervisor and fault registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WD_DISARMED;
         req_q    <= 1'b0;
         fvalid_q <= 1'b0;
         fchan_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         fvalid_q <= fvalid_d;
         fchan_q  <= fchan_d;
      end
   end

   assign armed        = (state_q == WD_ARMED);
   assign req_shutdown = req_q;
   assign fault_valid  = fvalid_q;
   assign fault_chan   = fchan_q;

endmodule

// File: tb/tb_step_watchdog.sv
// tb_step_watchdog: directed bench for step_watchdog (NCHAN=6, HZ=40 so the
// default timeout is 400 cycles, CNT_BITS=16 so the debug byte moves).
// Expected values are queued with the cycle they become due and compared
// after that clock edge.
module tb_step_watchdog;

   localparam int SIG_ARMED = 0;
   localparam int SIG_REQ   = 1;
   localparam int SIG_FV    = 2;
   localparam int SIG_FC    = 3;
   localparam int SIG_DBG   = 4;
   localparam int SIG_ALERT = 5;
   localparam int SIG_BIT0  = 10;

   typedef struct {
      int         due;
      int         sig;
      logic [7:0] exp;
      string      tag;
   } sb_t;

   logic        clk;
   logic        rst;
   logic [5:0]  step;
   logic [5:0]  shutdown_mask;
   logic        arm, disarm, clr, cfg_wr;
   logic [2:0]  cfg_chan;
   logic [15:0] cfg_timeout;
   logic [5:0]  alert;
   logic        armed, req_shutdown, fault_valid;
   logic [2:0]  fault_chan;
   logic [7:0]  dbg_idle_msb;

   sb_t sb[$];
   int  cyc;
   int  checks;
   int  errors;

   step_watchdog #(
      .NCHAN    (6),
      .HZ       (40),
      .CNT_BITS (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .step          (step),
      .shutdown_mask (shutdown_mask),
      .arm           (arm),
      .disarm        (disarm),
      .clr           (clr),
      .cfg_wr        (cfg_wr),
      .cfg_chan      (cfg_chan),
      .cfg_timeout   (cfg_timeout),
      .alert         (alert),
      .armed         (armed),
      .req_shutdown  (req_shutdown),
      .fault_valid   (fault_valid),
      .fault_chan    (fault_chan),
      .dbg_idle_msb  (dbg_idle_msb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] observe(int sig);
      logic [5:0] sh;
      case (sig)
         SIG_ARMED: return {7'b0, armed};
         SIG_REQ:   return {7'b0, req_shutdown};
         SIG_FV:    return {7'b0, fault_valid};
         SIG_FC:    return {5'b0, fault_chan};
         SIG_DBG:   return dbg_idle_msb;
         SIG_ALERT: return {2'b0, alert};
         default: begin
            sh = alert >> (sig - SIG_BIT0);
            return {7'b0, sh[0]};
         end
      endcase
   endfunction

   task automatic push_exp(int dly, int sig, logic [7:0] v, string tag);
      sb_t e;
      e.due = cyc + dly;
      e.sig = sig;
      e.exp = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_due();
      int         i;
      logic [7:0] obs;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due == cyc) begin
            obs = observe(sb[i].sig);
            checks++;
            assert (obs === sb[i].exp) else begin
               errors++;
               $error("FAIL %s @cyc %0d: observed %0h expected %0h", sb[i].tag, cyc, obs, sb[i].exp);
            end
            sb.delete(i);
         end else begin
            i++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      check_due();
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic cfg(int ch, int val);
      cfg_wr      = 1'b1;
      cfg_chan    = 3'(ch);
      cfg_timeout = 16'(val);
      tick();
      cfg_wr      = 1'b0;
   endtask

   initial begin
      cyc = 0; checks = 0; errors = 0;
      rst = 1'b1; step = '0; shutdown_mask = '0;
      arm = 1'b0; disarm = 1'b0; clr = 1'b0;
      cfg_wr = 1'b0; cfg_chan = '0; cfg_timeout = '0;

      // Reset values.
      tick();
      push_exp(1, SIG_ARMED, 8'd0, "rst_armed");
      push_exp(1, SIG_REQ,   8'd0, "rst_req");
      push_exp(1, SIG_FV,    8'd0, "rst_fv");
      push_exp(1, SIG_FC,    8'd0, "rst_fc");
      push_exp(1, SIG_DBG,   8'd0, "rst_dbg");
      push_exp(1, SIG_ALERT, 8'h00, "rst_alert");
      tick();
      rst = 1'b0;

      // Default timeout 400 on every idle channel; debug byte of channel 5.
      push_exp(198, SIG_DBG,   8'd0,  "dbg_198");
      push_exp(298, SIG_DBG,   8'd1,  "dbg_298");
      push_exp(400, SIG_ALERT, 8'h00, "dflt_pre");
      push_exp(401, SIG_ALERT, 8'h3f, "dflt_rise");
      push_exp(500, SIG_DBG,   8'd1,  "dbg_sat");
      run(410);

      // Channel 0 timeout 100: alert 101 cycles after the write.
      cfg(0, 100);
      push_exp(1,   SIG_BIT0, 8'd0, "a0_clear");
      push_exp(100, SIG_BIT0, 8'd0, "a0_pre");
      push_exp(101, SIG_BIT0, 8'd1, "a0_rise");
      push_exp(150, SIG_BIT0, 8'd1, "a0_hold");
      run(150);
      step[0] = 1'b1;
      push_exp(1, SIG_BIT0, 8'd1, "a0_toggle_same");
      push_exp(2, SIG_BIT0, 8'd0, "a0_toggle_drop");
      run(2);

      // Step change in the cycle the counter would reach 100.
      cfg(0, 100);
      run(99);
      step[0] = 1'b0;
      for (int k = 1; k <= 101; k++) push_exp(k, SIG_BIT0, 8'd0, "a0_edge_wins");
      push_exp(102, SIG_BIT0, 8'd1, "a0_restart");
      run(102);

      // Channels 2 and 4 timeout 50, arm after both alert: trip, lowest = 2.
      shutdown_mask = 6'b010100;
      cfg(4, 50);
      cfg(2, 50);
      push_exp(1,  SIG_BIT0 + 4, 8'd0, "a4_clear");
      push_exp(49, SIG_BIT0 + 4, 8'd0, "a4_pre");
      push_exp(50, SIG_BIT0 + 4, 8'd1, "a4_rise");
      push_exp(1,  SIG_BIT0 + 2, 8'd0, "a2_clear");
      push_exp(50, SIG_BIT0 + 2, 8'd0, "a2_pre");
      push_exp(51, SIG_BIT0 + 2, 8'd1, "a2_rise");
      push_exp(55, SIG_REQ,      8'd0, "no_trip_disarmed");
      run(58);
      push_exp(1,  SIG_ARMED, 8'd1, "arm_late_armed");
      push_exp(1,  SIG_REQ,   8'd0, "arm_late_req0");
      push_exp(2,  SIG_ARMED, 8'd0, "trip_armed0");
      push_exp(2,  SIG_REQ,   8'd1, "trip_req");
      push_exp(2,  SIG_FV,    8'd1, "trip_fv");
      push_exp(2,  SIG_FC,    8'd2, "trip_fc");
      push_exp(10, SIG_REQ,   8'd1, "trip_sticky");
      arm = 1'b1;
      tick();
      arm = 1'b0;
      run(9);
      clr = 1'b1;
      push_exp(1, SIG_REQ,   8'd0, "clr_req");
      push_exp(1, SIG_FV,    8'd0, "clr_fv");
      push_exp(1, SIG_FC,    8'd2, "clr_fc_hold");
      push_exp(1, SIG_ARMED, 8'd0, "clr_armed");
      tick();
      clr = 1'b0;
      run(2);

      // Timeout 0 on channel 1: never alerts, never trips while armed.
      shutdown_mask = 6'b000010;
      cfg(1, 0);
      run(1);
      arm = 1'b1;
      push_exp(1, SIG_ARMED, 8'd1, "t0_armed");
      tick();
      arm = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         push_exp(k * 1000, SIG_BIT0 + 1, 8'd0, "t0_alert");
         push_exp(k * 1000, SIG_REQ,      8'd0, "t0_req");
         push_exp(k * 1000, SIG_ARMED,    8'd1, "t0_still_armed");
      end
      run(10000);
      disarm = 1'b1;
      push_exp(1, SIG_ARMED, 8'd0, "disarm");
      tick();
      disarm = 1'b0;
      run(1);

      // arm and disarm together: stays disarmed.
      arm = 1'b1; disarm = 1'b1;
      push_exp(1, SIG_ARMED, 8'd0, "arm_disarm_1");
      push_exp(2, SIG_ARMED, 8'd0, "arm_disarm_2");
      tick();
      arm = 1'b0; disarm = 1'b0;
      run(1);

      // Masked alert and clr together while armed: no trip.
      shutdown_mask = 6'b000000;
      arm = 1'b1;
      push_exp(1, SIG_ARMED, 8'd1, "arm_nomask");
      tick();
      arm = 1'b0;
      run(1);
      shutdown_mask = 6'b000100;
      clr = 1'b1;
      push_exp(1, SIG_ARMED, 8'd0, "clr_vs_trip_armed");
      push_exp(1, SIG_REQ,   8'd0, "clr_vs_trip_req");
      push_exp(1, SIG_FV,    8'd0, "clr_vs_trip_fv");
      push_exp(3, SIG_REQ,   8'd0, "clr_vs_trip_req_late");
      tick();
      clr = 1'b0;
      shutdown_mask = 6'b000000;
      run(3);

      // Rewrite channel 3 mid-count, then an out-of-range write.
      cfg(3, 1000);
      run(500);
      cfg(3, 10);
      push_exp(1,  SIG_BIT0 + 3, 8'd0, "a3_rewrite_clear");
      push_exp(10, SIG_BIT0 + 3, 8'd0, "a3_pre");
      push_exp(11, SIG_BIT0 + 3, 8'd1, "a3_rise");
      push_exp(20, SIG_BIT0 + 3, 8'd1, "a3_hold");
      run(20);
      cfg(7, 5);
      push_exp(1,  SIG_ALERT, 8'h3d, "oor_write_1");
      push_exp(20, SIG_ALERT, 8'h3d, "oor_write_20");
      run(20);

      // Reset while TRIPPED restores everything.
      shutdown_mask = 6'b001000;
      arm = 1'b1;
      push_exp(2, SIG_REQ, 8'd1, "trip3_req");
      push_exp(2, SIG_FC,  8'd3, "trip3_fc");
      tick();
      arm = 1'b0;
      tick();
      rst = 1'b1;
      push_exp(1, SIG_ARMED, 8'd0,  "rst2_armed");
      push_exp(1, SIG_REQ,   8'd0,  "rst2_req");
      push_exp(1, SIG_FV,    8'd0,  "rst2_fv");
      push_exp(1, SIG_FC,    8'd0,  "rst2_fc");
      push_exp(1, SIG_DBG,   8'd0,  "rst2_dbg");
      push_exp(1, SIG_ALERT, 8'h00, "rst2_alert");
      tick();
      rst = 1'b0;
      shutdown_mask = 6'b000000;
      push_exp(1, SIG_ALERT, 8'h00, "post_rst_alert");
      push_exp(1, SIG_ARMED, 8'd0,  "post_rst_armed");
      tick();
      run(2);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
